// File: rtl/md_unit.sv
// md_unit: multi-cycle mult/div sequencer with HI/LO registers and D-stage stall request
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic        op_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out,
  output logic        md_stall
);
  localparam int NMAX = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = NMAX > 1 ? $clog2(NMAX) : 1;
  localparam logic [CW-1:0] MLOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DLOAD = CW'(DIV_CYCLES - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] op_r, op_n;
  logic [31:0] a_r, b_r, a_n, b_n, hi_n, lo_n, ma, mb, q, r;
  logic [63:0] sa, sb, prod, res;
  logic issue, sgn;
  assign issue = start & op_valid & ~md_op[2];
  assign busy = state == RUN;
  assign md_stall = d_is_md & (busy | issue);
  assign md_out = md_op == 3'd4 ? hi : md_op == 3'd5 ? lo : '0;
  // signed ops use sign extension for mult and magnitude division with sign fix-up for div
  assign sgn = ~op_r[0];
  assign sa = {{32{sgn & a_r[31]}}, a_r};
  assign sb = {{32{sgn & b_r[31]}}, b_r};
  assign prod = sa * sb;
  assign ma = (sgn & a_r[31]) ? -a_r : a_r;
  assign mb = (sgn & b_r[31]) ? -b_r : b_r;
  assign q = mb == '0 ? '0 : ma / mb;
  assign r = mb == '0 ? '0 : ma % mb;
  assign res = op_r[1] ? {(sgn & a_r[31]) ? -r : r, (sgn & (a_r[31] ^ b_r[31])) ? -q : q} : prod;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    op_n = op_r;
    a_n = a_r;
    b_n = b_r;
    hi_n = hi;
    lo_n = lo;
    if (state == IDLE) begin
      if (issue) begin
        state_n = RUN;
        cnt_n = md_op[1] ? DLOAD : MLOAD;
        op_n = md_op[1:0];
        a_n = a;
        b_n = b;
      end else if (op_valid && md_op == 3'd6) hi_n = a;
      else if (op_valid && md_op == 3'd7) lo_n = a;
    end else if (cnt == '0) begin
      state_n = IDLE;
      if (!(op_r[1] && b_r == '0)) {hi_n, lo_n} = res;
    end else cnt_n = cnt - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      op_r <= op_n;
      a_r <= a_n;
      b_r <= b_n;
      hi <= hi_n;
      lo <= lo_n;
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: random and directed checks of md_unit against a behavioural HI/LO model
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;
  logic clk = 0, reset = 0, start = 0, op_valid = 0, d_is_md = 0;
  logic [2:0] md_op = 0;
  logic [31:0] a = 0, b = 0;
  logic busy, md_stall;
  logic [31:0] hi, lo, md_out;
  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .op_valid(op_valid),
    .a(a), .b(b), .d_is_md(d_is_md), .busy(busy), .hi(hi), .lo(lo),
    .md_out(md_out), .md_stall(md_stall)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, stall_cnt = 0;
  bit chk_en = 0;
  logic [31:0] m_hi = 0, m_lo = 0, r_hi = 0, r_lo = 0;
  int m_rem = 0;
  bit m_commit = 0;
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  // model: m_rem counts remaining busy cycles; result lands when it reaches zero
  always @(posedge clk) begin
    if (reset) begin
      m_hi = 0; m_lo = 0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && m_commit) begin m_hi = r_hi; m_lo = r_lo; end
    end else if (op_valid) begin
      if (start && md_op <= 3) begin
        m_rem = md_op >= 2 ? DC : MC;
        m_commit = !(md_op >= 2 && b == 0);
        case (md_op)
          3'd0: {r_hi, r_lo} = longint'($signed(a)) * longint'($signed(b));
          3'd1: {r_hi, r_lo} = {32'b0, a} * {32'b0, b};
          3'd2: if (b != 0) begin
            r_lo = 32'(longint'($signed(a)) / longint'($signed(b)));
            r_hi = 32'(longint'($signed(a)) % longint'($signed(b)));
          end
          default: if (b != 0) begin r_lo = a / b; r_hi = a % b; end
        endcase
      end else if (md_op == 6) m_hi = a;
      else if (md_op == 7) m_lo = a;
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("busy", 32'(busy), 32'(m_rem > 0));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("md_out", md_out, md_op == 4 ? m_hi : md_op == 5 ? m_lo : 32'h0);
    chk("md_stall", 32'(md_stall), 32'(d_is_md && (m_rem > 0 || (start && op_valid && md_op <= 3))));
    if (md_stall) stall_cnt++;
  end
  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic drive(bit s, bit v, logic [2:0] op, logic [31:0] x, logic [31:0] y);
    start = s; op_valid = v; md_op = op; a = x; b = y;
  endtask
  task automatic run(logic [2:0] op, logic [31:0] x, logic [31:0] y);
    drive(1, 1, op, x, y);
    cyc(1);
    chk("busy_issue", 32'(busy), 1);
    drive(0, 0, 0, 0, 0);
    cyc(op >= 2 ? DC : MC);
    chk("busy_done", 32'(busy), 0);
  endtask
  function automatic logic [31:0] pick();
    int k = $urandom_range(0, 7);
    return k == 0 ? 32'h0 : k == 1 ? 32'hFFFFFFFF : k == 2 ? 32'h80000000 : k == 3 ? 32'($urandom_range(0, 9)) : $urandom;
  endfunction
  initial begin
    reset = 1;
    cyc(2);
    chk_en = 1;
    reset = 0;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", 32'(busy), 0);
    drive(0, 1, 6, 32'h12345678, 0);
    cyc(1);
    chk("mthi", hi, 32'h12345678);
    drive(0, 1, 5, 0, 0);
    #1 chk("mflo_out", md_out, 0);
    cyc(1);
    run(0, 32'hFFFFFFFF, 2);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFE);
    run(1, 32'hFFFFFFFF, 2);
    chk("multu_hi", hi, 1);
    chk("multu_lo", lo, 32'hFFFFFFFE);
    run(2, 32'hFFFFFFF9, 2);
    chk("div_hi", hi, 32'hFFFFFFFF);
    chk("div_lo", lo, 32'hFFFFFFFD);
    run(3, 7, 0);
    chk("div0_hi", hi, 32'hFFFFFFFF);
    chk("div0_lo", lo, 32'hFFFFFFFD);
    d_is_md = 1;
    stall_cnt = 0;
    drive(1, 1, 0, 3, 4);
    cyc(1);
    drive(0, 0, 0, 0, 0);
    cyc(2);
    drive(1, 1, 0, 5, 5);
    cyc(1);
    drive(0, 0, 0, 0, 0);
    cyc(4);
    d_is_md = 0;
    chk("stall_cycles", 32'(stall_cnt), MC + 1);
    chk("ignore_hi", hi, 0);
    chk("ignore_lo", lo, 12);
    drive(1, 1, 2, 100, 7);
    cyc(1);
    drive(0, 0, 0, 0, 0);
    cyc(2);
    reset = 1;
    cyc(1);
    reset = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_lo", lo, 0);
    cyc(DC + 2);
    chk("abort_late_hi", hi, 0);
    chk("abort_late_lo", lo, 0);
    run(2, 32'h80000000, 32'hFFFFFFFF);
    chk("ovf_hi", hi, 0);
    chk("ovf_lo", lo, 32'h80000000);
    for (int i = 0; i < 600; i++) begin
      reset = $urandom_range(0, 63) == 0;
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)), pick(), pick());
      d_is_md = $urandom_range(0, 1) == 1;
      cyc(1);
    end
    reset = 0;
    drive(0, 0, 0, 0, 0);
    cyc(DC + 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
